// File: rtl/ili_bus_writer.sv
// ILI9341 8080-style write engine behind an Avalon-MM slave.
// Ports: Avalon (address/chipselect/write_n/writedata/readdata/waitrequest),
//   ncs_in from CS PIO, panel pins lcd_cs_n/lcd_rs/lcd_wr_n/lcd_rd_n/lcd_db.
// Option macro ILI_BUS_WAITREQ_EN: stall pushes on full instead of dropping.
module ili_bus_writer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DW          = 16,
    parameter int WR_LOW_DEF  = 2,
    parameter int WR_HIGH_DEF = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          waitrequest,
    input  logic          ncs_in,
    output logic          lcd_cs_n,
    output logic          lcd_rs,
    output logic          lcd_wr_n,
    output logic          lcd_rd_n,
    output logic [DW-1:0] lcd_db
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE, SETUP, WR_LOW, WR_HIGH
    } state_t;

    logic [DW:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      timing_q, timing_d;
    logic            ovf_q;
    state_t          state_q;
    logic [3:0]      cnt_q, low_q, high_q;
    logic            rs_q, wr_n_q;
    logic [DW-1:0]   db_q;

    logic wr_en, push_req, push, pop;
    logic full, empty, busy, ovf_set;
    logic [DW:0] head;
    logic [3:0]  tlow, thigh;
    logic        unused_wd;

    assign unused_wd = &{1'b0, writedata};

    assign wr_en    = chipselect & ~write_n;
    assign push_req = wr_en & ~address[1];
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    // full is judged on the pre-pop level, so a same-cycle pop cannot admit it
    assign push     = push_req & ~full;
    assign pop      = ~empty & ((state_q == IDLE) |
                      ((state_q == WR_HIGH) & (cnt_q == 4'd0)));
    assign head     = mem_q[rptr_q];
    assign busy     = (state_q != IDLE) | ~empty;
    assign level_d  = level_q + LW'(push) - LW'(pop);

`ifdef ILI_BUS_WAITREQ_EN
    assign waitrequest = push_req & full;
    assign ovf_set     = 1'b0;
`else
    assign waitrequest = 1'b0;
    assign ovf_set     = push_req & full;
`endif

    // zero phase lengths are stored as 1 so readback shows the real value
    assign tlow     = (writedata[3:0] == 4'd0) ? 4'd1 : writedata[3:0];
    assign thigh    = (writedata[7:4] == 4'd0) ? 4'd1 : writedata[7:4];
    assign timing_d = (wr_en && address == 2'd3) ? {thigh, tlow} : timing_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {address[0], writedata[DW-1:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            timing_q <= {4'(WR_HIGH_DEF), 4'(WR_LOW_DEF)};
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            low_q    <= 4'd1;
            high_q   <= 4'd1;
            rs_q     <= 1'b1;
            db_q     <= '0;
            wr_n_q   <= 1'b1;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q  <= level_d;
            timing_q <= timing_d;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_en && address == 2'd2) begin
                ovf_q <= 1'b0;
            end
            // every pop loads the bus and snapshots the phase lengths
            if (pop) begin
                rs_q   <= head[DW];
                db_q   <= head[DW-1:0];
                low_q  <= timing_q[3:0];
                high_q <= timing_q[7:4];
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) state_q <= SETUP;
                end
                SETUP: begin
                    state_q <= WR_LOW;
                    wr_n_q  <= 1'b0;
                    cnt_q   <= low_q - 4'd1;
                end
                WR_LOW: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= WR_HIGH;
                        wr_n_q  <= 1'b1;
                        cnt_q   <= high_q - 4'd1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                WR_HIGH: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (pop) begin
                        state_q <= SETUP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd2: begin
                readdata[0]    = busy;
                readdata[1]    = full;
                readdata[2]    = ovf_q;
                readdata[14:8] = 7'(level_q);
            end
            2'd3:    readdata[7:0] = timing_q;
            default: readdata = 32'd0;
        endcase
    end

    assign lcd_cs_n = busy ? 1'b0 : ncs_in;
    assign lcd_rs   = rs_q;
    assign lcd_wr_n = wr_n_q;
    assign lcd_rd_n = 1'b1;
    assign lcd_db   = db_q;

endmodule
